sap_controller_sequencer: RTL and testbench
===========================================

Name: sap_controller_sequencer

Overview:
Control/sequencer stage for the 8-bit CPU. It sits directly upstream of the program counter and generates its control inputs: count, output-enable, load and synchronous clear. It also generates the control word for MAR, RAM, IR, A, B, ALU and output registers. A one-hot T-state ring runs fetch (T1–T3) and opcode-dependent execute (T4–T6).

Parameters:
OP_LDA, 4'h0, load A from memory
OP_ADD, 4'h1, A <= A + B(mem)
OP_SUB, 4'h2, A <= A - B(mem)
OP_JMP, 4'h3, PC <= IR operand
OP_OUT, 4'hE, output register <= A
OP_HLT, 4'hF, stop sequencer

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = ring advances; 0 = stall, all control outputs forced 0 (pc_clr_n unaffected)
opcode  in  4  IR upper nibble, valid from T4 onward
pc_clr_n  out  1  PC synchronous clear, active-low
pc_cp  out  1  PC count enable
pc_ep  out  1  PC bus output enable
pc_lp  out  1  PC load from bus
mar_lm  out  1  MAR load
ram_ce  out  1  RAM drive bus
ir_li  out  1  IR load
ir_ei  out  1  IR operand drive bus
a_la  out  1  A load
a_ea  out  1  A drive bus
alu_su  out  1  ALU subtract select
alu_eu  out  1  ALU drive bus
b_lb  out  1  B load
out_lo  out  1  output register load
t_state  out  6  one-hot ring state, bit0 = T1
halted  out  1  sequencer halted

Behaviour:
- States: INIT, T1..T6, HALT. rst -> INIT asynchronously: pc_clr_n=0, t_state=6'b0, halted=0, all other outputs 0.
- INIT: pc_clr_n=0 for one cycle, so the PC clears on that edge. Next edge goes to T1 regardless of run. pc_clr_n=1 in all other states.
- Ring order T1->T2->...->T6->T1. Advances on each edge only when run=1. run=0 holds state and zeroes the control word; resuming re-asserts the held state's word once, with no double count.
- Control outputs are a pure decode of registered state, opcode and run. Unlisted outputs are 0.
- T1: pc_ep, mar_lm.
- T2: pc_cp.
- T3: ram_ce, ir_li.
- LDA: T4 ir_ei, mar_lm; T5 ram_ce, a_la; T6 none.
- ADD: T4 ir_ei, mar_lm; T5 ram_ce, b_lb; T6 alu_eu, a_la.
- SUB: same as ADD, plus alu_su in T6.
- JMP: T4 ir_ei, pc_lp; T5, T6 none.
- OUT: T4 a_ea, out_lo; T5, T6 none.
- HLT: T4 decodes, no outputs. Next edge with run=1 -> HLT state: halted=1, t_state=0, all control 0. Exit only by rst.
- Unknown opcode: T4–T6 produce no control outputs (NOP).
- Bus exclusivity: at most one of pc_ep, ram_ce, ir_ei, a_ea, alu_eu high in any cycle. Assertion required in RTL sim.
- No illegal one-hot states reachable. Any non-one-hot t_state recovers to T1 next edge.

Optional Feature:
SAP_SKIP_NOP_EN: when defined, the ring returns to T1 directly after the last non-empty T-state for the opcode.
- LDA: T5->T1.
- JMP and OUT: T4->T1.
- Unknown opcode: T4->T1.
- ADD/SUB unchanged (full T6).
When undefined, every instruction takes exactly 6 T-states.

Test Plan:
- Reset: rst=1 mid-T5 -> immediately INIT, pc_clr_n=0, t_state=0. Release -> one cycle pc_clr_n=0, then t_state=6'b000001 with pc_ep=mar_lm=1.
- Fetch+LDA, run=1, opcode=0 -> T1 {pc_ep,mar_lm}, T2 {pc_cp}, T3 {ram_ce,ir_li}, T4 {ir_ei,mar_lm}, T5 {ram_ce,a_la}, T6 {}, back to T1 on 7th edge.
- SUB opcode=2 -> T6 shows alu_su=alu_eu=a_la=1, b_lb=0. ADD opcode=1 -> same T6 with alu_su=0.
- Stall: run=0 during T2 for 3 cycles -> pc_cp=0 and t_state held at T2. run=1 -> pc_cp high exactly one cycle, then T3.
- HLT opcode=F -> after T4, halted=1, all controls 0 for 20 cycles, then rst recovers to INIT.
- With SAP_SKIP_NOP_EN, opcode=3 -> T4 {ir_ei,pc_lp}, next state T1 (instruction = 4 cycles). Without it, 6 cycles.

Source files
------------

// File: rtl/sap_controller_sequencer.sv
// SAP-1 style control sequencer: one-hot T1..T6 ring plus INIT/HALT modes, decoding the PC and datapath control word.
// Optional SAP_SKIP_NOP_EN returns to T1 right after the last non-empty T-state of each opcode.
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_JMP = 4'h3,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic [3:0] opcode_i,
  output logic       pc_clr_n_o,
  output logic       pc_cp_o,
  output logic       pc_ep_o,
  output logic       pc_lp_o,
  output logic       mar_lm_o,
  output logic       ram_ce_o,
  output logic       ir_li_o,
  output logic       ir_ei_o,
  output logic       a_la_o,
  output logic       a_ea_o,
  output logic       alu_su_o,
  output logic       alu_eu_o,
  output logic       b_lb_o,
  output logic       out_lo_o,
  output logic [5:0] t_state_o,
  output logic       halted_o
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_e;

  localparam logic [5:0] T1 = 6'b000001;

  state_e     state_q, state_d;
  logic [5:0] ring_q, ring_d;
  logic       ring_ok;
  logic       skip_now;

  assign ring_ok = (ring_q != 6'd0) && ((ring_q & (ring_q - 6'd1)) == 6'd0);

`ifdef SAP_SKIP_NOP_EN
  logic op_unknown;
  assign op_unknown = !(opcode_i inside {OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT});
  assign skip_now = (ring_q[4] && opcode_i == OP_LDA) ||
                    (ring_q[3] && (opcode_i == OP_JMP || opcode_i == OP_OUT || op_unknown));
`else
  assign skip_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_RUN;
        ring_d  = T1;
      end
      S_RUN: begin
        if (!ring_ok) begin
          ring_d = T1;
        end else if (run_i) begin
          if (ring_q[3] && opcode_i == OP_HLT) begin
            state_d = S_HALT;
            ring_d  = 6'd0;
          end else if (skip_now) begin
            ring_d = T1;
          end else begin
            ring_d = {ring_q[4:0], ring_q[5]};
          end
        end
      end
      S_HALT: begin
        ring_d = 6'd0;
      end
      default: begin
        state_d = S_INIT;
        ring_d  = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ring_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
    end
  end

  assign pc_clr_n_o = (state_q != S_INIT);
  assign halted_o   = (state_q == S_HALT);
  assign t_state_o  = ring_q;

  // Stall (run low) or a corrupt ring blanks the whole control word.
  always_comb begin
    pc_cp_o  = 1'b0;
    pc_ep_o  = 1'b0;
    pc_lp_o  = 1'b0;
    mar_lm_o = 1'b0;
    ram_ce_o = 1'b0;
    ir_li_o  = 1'b0;
    ir_ei_o  = 1'b0;
    a_la_o   = 1'b0;
    a_ea_o   = 1'b0;
    alu_su_o = 1'b0;
    alu_eu_o = 1'b0;
    b_lb_o   = 1'b0;
    out_lo_o = 1'b0;
    if (run_i && state_q == S_RUN && ring_ok) begin
      if (ring_q[0]) begin
        pc_ep_o  = 1'b1;
        mar_lm_o = 1'b1;
      end
      if (ring_q[1]) pc_cp_o = 1'b1;
      if (ring_q[2]) begin
        ram_ce_o = 1'b1;
        ir_li_o  = 1'b1;
      end
      if (ring_q[3]) begin
        if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ir_ei_o  = 1'b1;
          mar_lm_o = 1'b1;
        end else if (opcode_i == OP_JMP) begin
          ir_ei_o = 1'b1;
          pc_lp_o = 1'b1;
        end else if (opcode_i == OP_OUT) begin
          a_ea_o   = 1'b1;
          out_lo_o = 1'b1;
        end
      end
      if (ring_q[4]) begin
        if (opcode_i == OP_LDA) begin
          ram_ce_o = 1'b1;
          a_la_o   = 1'b1;
        end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ram_ce_o = 1'b1;
          b_lb_o   = 1'b1;
        end
      end
      if (ring_q[5] && (opcode_i == OP_ADD || opcode_i == OP_SUB)) begin
        alu_eu_o = 1'b1;
        a_la_o   = 1'b1;
        alu_su_o = (opcode_i == OP_SUB);
      end
    end
  end

`ifndef SYNTHESIS
  bus_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0({pc_ep_o, ram_ce_o, ir_ei_o, a_ea_o, alu_eu_o}))
    else $error("bus contention between drivers");
`endif

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed bench for sap_controller_sequencer: fetch/execute words, stall, halt, reset and instruction length.
module tb_sap_controller_sequencer;

  logic       clk, rst, run_i;
  logic [3:0] opcode_i;
  logic       pc_clr_n_o, pc_cp_o, pc_ep_o, pc_lp_o, mar_lm_o, ram_ce_o, ir_li_o, ir_ei_o;
  logic       a_la_o, a_ea_o, alu_su_o, alu_eu_o, b_lb_o, out_lo_o, halted_o;
  logic [5:0] t_state_o;
  logic [12:0] cw;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SAP_SKIP_NOP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Control word bit order: cp ep lp lm ce li ei la ea su eu lb lo
  localparam logic [12:0] CW_T1   = 13'h0A00;
  localparam logic [12:0] CW_T2   = 13'h1000;
  localparam logic [12:0] CW_T3   = 13'h0180;
  localparam logic [12:0] CW_T4M  = 13'h0240;
  localparam logic [12:0] CW_T5L  = 13'h0120;
  localparam logic [12:0] CW_T5B  = 13'h0102;
  localparam logic [12:0] CW_T6A  = 13'h0024;
  localparam logic [12:0] CW_T6S  = 13'h002C;
  localparam logic [12:0] CW_JMP  = 13'h0440;
  localparam logic [12:0] CW_OUT  = 13'h0011;
  localparam logic [12:0] CW_NONE = 13'h0000;

  assign cw = {pc_cp_o, pc_ep_o, pc_lp_o, mar_lm_o, ram_ce_o, ir_li_o, ir_ei_o,
               a_la_o, a_ea_o, alu_su_o, alu_eu_o, b_lb_o, out_lo_o};

  sap_controller_sequencer dut (
    .clk(clk), .rst(rst), .run_i(run_i), .opcode_i(opcode_i),
    .pc_clr_n_o(pc_clr_n_o), .pc_cp_o(pc_cp_o), .pc_ep_o(pc_ep_o), .pc_lp_o(pc_lp_o),
    .mar_lm_o(mar_lm_o), .ram_ce_o(ram_ce_o), .ir_li_o(ir_li_o), .ir_ei_o(ir_ei_o),
    .a_la_o(a_la_o), .a_ea_o(a_ea_o), .alu_su_o(alu_su_o), .alu_eu_o(alu_eu_o),
    .b_lb_o(b_lb_o), .out_lo_o(out_lo_o), .t_state_o(t_state_o), .halted_o(halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (pc_clr_n_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_clr: got %b expected 0", pc_clr_n_o); end
    n_cmp++; if (t_state_o !== 6'd0) begin n_bad++; $display("[TB] FAIL rst_t: got %b expected 000000", t_state_o); end
    n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_halt: got %b expected 0", halted_o); end
    n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL rst_cw: got %h expected %h", cw, CW_NONE); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (pc_clr_n_o !== 1'b0) begin n_bad++; $display("[TB] FAIL init_clr: got %b expected 0", pc_clr_n_o); end
    step();
    n_cmp++; if (t_state_o !== 6'b000001) begin n_bad++; $display("[TB] FAIL init_to_t1: got %b expected 000001", t_state_o); end
    n_cmp++; if (pc_clr_n_o !== 1'b1) begin n_bad++; $display("[TB] FAIL t1_clr: got %b expected 1", pc_clr_n_o); end
    n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL t1_run0_cw: got %h expected %h", cw, CW_NONE); end
    run_i = 1'b1;
    #1;
    n_cmp++; if (cw !== CW_T1) begin n_bad++; $display("[TB] FAIL t1_cw: got %h expected %h", cw, CW_T1); end
  endtask

  task automatic test_lda();
    logic [5:0]  et[6];
    logic [12:0] ec[6];
    int len;
    et = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    ec = '{CW_T1, CW_T2, CW_T3, CW_T4M, CW_T5L, CW_NONE};
    len = SKIP ? 5 : 6;
    opcode_i = 4'h0;
    for (int i = 0; i < len; i++) begin
      n_cmp++; if (t_state_o !== et[i]) begin n_bad++; $display("[TB] FAIL lda_t%0d: got %b expected %b", i + 1, t_state_o, et[i]); end
      n_cmp++; if (cw !== ec[i]) begin n_bad++; $display("[TB] FAIL lda_cw%0d: got %h expected %h", i + 1, cw, ec[i]); end
      step();
    end
    n_cmp++; if (t_state_o !== 6'd1) begin n_bad++; $display("[TB] FAIL lda_wrap: got %b expected 000001", t_state_o); end
  endtask

  task automatic test_alu();
    logic [5:0]  et[6];
    logic [12:0] ec[6];
    logic [3:0]  ops[2];
    ops = '{4'h2, 4'h1};
    et = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    for (int k = 0; k < 2; k++) begin
      opcode_i = ops[k];
      ec = '{CW_T1, CW_T2, CW_T3, CW_T4M, CW_T5B, (ops[k] == 4'h2) ? CW_T6S : CW_T6A};
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (t_state_o !== et[i]) begin n_bad++; $display("[TB] FAIL alu%0h_t%0d: got %b expected %b", ops[k], i + 1, t_state_o, et[i]); end
        n_cmp++; if (cw !== ec[i]) begin n_bad++; $display("[TB] FAIL alu%0h_cw%0d: got %h expected %h", ops[k], i + 1, cw, ec[i]); end
        step();
      end
      n_cmp++; if (t_state_o !== 6'd1) begin n_bad++; $display("[TB] FAIL alu%0h_wrap: got %b expected 000001", ops[k], t_state_o); end
    end
  endtask

  // JMP, OUT and an undefined opcode share the same shape: one optional T4 word, then empty states.
  task automatic test_short_ops();
    logic [3:0]  ops[3];
    logic [12:0] w4[3];
    int cycles;
    ops = '{4'h3, 4'hE, 4'h7};
    w4  = '{CW_JMP, CW_OUT, CW_NONE};
    for (int k = 0; k < 3; k++) begin
      opcode_i = ops[k];
      step(); step(); step();
      n_cmp++; if (t_state_o !== 6'd8) begin n_bad++; $display("[TB] FAIL op%0h_t4: got %b expected 001000", ops[k], t_state_o); end
      n_cmp++; if (cw !== w4[k]) begin n_bad++; $display("[TB] FAIL op%0h_cw4: got %h expected %h", ops[k], cw, w4[k]); end
      cycles = 4;
      step();
      while (t_state_o !== 6'd1 && cycles < 10) begin
        n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL op%0h_tail: got %h expected %h", ops[k], cw, CW_NONE); end
        cycles++;
        step();
      end
      n_cmp++; if (cycles !== (SKIP ? 4 : 6)) begin n_bad++; $display("[TB] FAIL op%0h_len: got %0d expected %0d", ops[k], cycles, SKIP ? 4 : 6); end
    end
  endtask

  task automatic test_stall();
    opcode_i = 4'h1;
    step();
    run_i = 1'b0;
    #1;
    n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL stall_cw0: got %h expected %h", cw, CW_NONE); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (t_state_o !== 6'd2) begin n_bad++; $display("[TB] FAIL stall_hold%0d: got %b expected 000010", i, t_state_o); end
      n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL stall_cw%0d: got %h expected %h", i + 1, cw, CW_NONE); end
    end
    run_i = 1'b1;
    #1;
    n_cmp++; if (cw !== CW_T2) begin n_bad++; $display("[TB] FAIL resume_cp: got %h expected %h", cw, CW_T2); end
    step();
    n_cmp++; if (t_state_o !== 6'd4) begin n_bad++; $display("[TB] FAIL resume_t3: got %b expected 000100", t_state_o); end
    n_cmp++; if (cw !== CW_T3) begin n_bad++; $display("[TB] FAIL resume_cw3: got %h expected %h", cw, CW_T3); end
    step(); step(); step(); step();
    n_cmp++; if (t_state_o !== 6'd1) begin n_bad++; $display("[TB] FAIL stall_wrap: got %b expected 000001", t_state_o); end
  endtask

  task automatic test_halt();
    opcode_i = 4'hF;
    step(); step(); step();
    n_cmp++; if (t_state_o !== 6'd8) begin n_bad++; $display("[TB] FAIL hlt_t4: got %b expected 001000", t_state_o); end
    n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL hlt_cw4: got %h expected %h", cw, CW_NONE); end
    for (int i = 0; i < 20; i++) begin
      step();
      opcode_i = 4'(i);
      #1;
      n_cmp++;
      if ({halted_o, t_state_o, cw} !== {1'b1, 6'd0, CW_NONE}) begin
        n_bad++;
        $display("[TB] FAIL hlt_hold%0d: got halted=%b t=%b cw=%h expected halted=1 t=000000 cw=0000", i, halted_o, t_state_o, cw);
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({halted_o, pc_clr_n_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL hlt_rst: got halted=%b clr_n=%b expected 0 0", halted_o, pc_clr_n_o); end
    @(negedge clk);
    rst = 1'b0;
    opcode_i = 4'h0;
    step();
    n_cmp++; if (t_state_o !== 6'd1) begin n_bad++; $display("[TB] FAIL hlt_recover: got %b expected 000001", t_state_o); end
  endtask

  task automatic test_reset_mid();
    opcode_i = 4'h0;
    step(); step(); step(); step();
    n_cmp++; if (t_state_o !== 6'd16) begin n_bad++; $display("[TB] FAIL mid_t5: got %b expected 010000", t_state_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (pc_clr_n_o !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_clr: got %b expected 0", pc_clr_n_o); end
    n_cmp++; if (t_state_o !== 6'd0) begin n_bad++; $display("[TB] FAIL mid_t: got %b expected 000000", t_state_o); end
    n_cmp++; if (cw !== CW_NONE) begin n_bad++; $display("[TB] FAIL mid_cw: got %h expected %h", cw, CW_NONE); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (pc_clr_n_o !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_init: got %b expected 0", pc_clr_n_o); end
    step();
    n_cmp++; if (t_state_o !== 6'd1) begin n_bad++; $display("[TB] FAIL mid_t1: got %b expected 000001", t_state_o); end
    n_cmp++; if (cw !== CW_T1) begin n_bad++; $display("[TB] FAIL mid_cw1: got %h expected %h", cw, CW_T1); end
  endtask

  initial begin
    rst      = 1'b1;
    run_i    = 1'b0;
    opcode_i = 4'h0;
    test_reset();
    test_lda();
    test_alu();
    test_short_ops();
    test_stall();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
